// File: rtl/lm75a_temp_display.sv
// lm75a_temp_display: converts an LM75A temperature word to signed decimal with one fractional digit
// and scans it onto a 4-digit multiplexed active-low 7-segment display.
module lm75a_temp_display #(
    parameter int REFRESH_DIV = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    output logic        busy,
    output logic        done,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH = 7'h3F;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: seg_of = 7'h40;
            4'd1: seg_of = 7'h79;
            4'd2: seg_of = 7'h24;
            4'd3: seg_of = 7'h30;
            4'd4: seg_of = 7'h19;
            4'd5: seg_of = 7'h12;
            4'd6: seg_of = 7'h02;
            4'd7: seg_of = 7'h78;
            4'd8: seg_of = 7'h00;
            4'd9: seg_of = 7'h10;
            default: seg_of = BLANK;
        endcase
    endfunction

    function automatic logic [3:0] tenths_of(input logic [2:0] f);
        case (f)
            3'd0: tenths_of = 4'd0;
            3'd1: tenths_of = 4'd1;
            3'd2: tenths_of = 4'd2;
            3'd3: tenths_of = 4'd3;
            3'd4: tenths_of = 4'd5;
            3'd5: tenths_of = 4'd6;
            3'd6: tenths_of = 4'd7;
            default: tenths_of = 4'd8;
        endcase
    endfunction

    function automatic logic [11:0] dd_adj(input logic [11:0] b);
        dd_adj = b;
        for (int i = 0; i < 3; i++)
            if (b[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = b[4*i +: 4] + 4'd3;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   last_q, last_d;
    logic          force_q, force_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [7:0]    bin_q, bin_d;
    logic [2:0]    it_q, it_d;
    logic [2:0]    frac_q, frac_d;
    logic          neg_q, neg_d;
    logic [6:0]    disp_q [4];
    logic [6:0]    disp_d [4];
    logic          dp_on_q, dp_on_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [10:0] t;
    logic [11:0] mag;
    logic [3:0]  hun, ten, uni;
    logic        err;

    assign t   = data[15:5];
    assign mag = t[10] ? 12'h800 - {1'b0, t} : {1'b0, t};
    assign hun = bcd_q[11:8];
    assign ten = bcd_q[7:4];
    assign uni = bcd_q[3:0];
    // a nonzero hundreds digit on a negative reading can only come from an out-of-range word
    assign err = neg_q && hun != 4'd0;

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign busy = busy_q;
    assign done = done_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        force_d = force_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        it_d    = it_q;
        frac_d  = frac_q;
        neg_d   = neg_q;
        disp_d  = disp_q;
        dp_on_d = dp_on_q;
        cnt_d   = cnt_q == CNT_MAX ? '0 : cnt_q + 1'b1;
        idx_d   = cnt_q == CNT_MAX ? idx_q + 2'd1 : idx_q;
        an_d    = ~(4'b0001 << idx_q);
        seg_d   = disp_q[idx_q];
        dp_d    = ~(dp_on_q && idx_q == 2'd1);
        case (state_q)
            IDLE: if (force_q || data != last_q) begin
                last_d  = data;
                force_d = 1'b0;
                bin_d   = 8'(mag >> 3);
                frac_d  = mag[2:0];
                neg_d   = t[10];
                bcd_d   = '0;
                it_d    = '0;
                state_d = CONV;
            end
            CONV: begin
                {bcd_d, bin_d} = {dd_adj(bcd_q), bin_q} << 1;
                it_d    = it_q + 3'd1;
                state_d = it_q == 3'd7 ? DONE : CONV;
            end
            DONE: begin
                disp_d[3] = neg_q ? DASH : (hun != 4'd0 ? seg_of(hun) : BLANK);
                disp_d[2] = err ? DASH : (hun == 4'd0 && ten == 4'd0 ? BLANK : seg_of(ten));
                disp_d[1] = err ? DASH : seg_of(uni);
                disp_d[0] = err ? DASH : seg_of(tenths_of(frac_q));
                dp_on_d   = !err;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            force_q <= 1'b1;
            bcd_q   <= '0;
            bin_q   <= '0;
            it_q    <= '0;
            frac_q  <= '0;
            neg_q   <= 1'b0;
            disp_q  <= '{default: BLANK};
            dp_on_q <= 1'b0;
            an_q    <= 4'hF;
            seg_q   <= BLANK;
            dp_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            force_q <= force_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            it_q    <= it_d;
            frac_q  <= frac_d;
            neg_q   <= neg_d;
            disp_q  <= disp_d;
            dp_on_q <= dp_on_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_lm75a_temp_display.sv
// tb_lm75a_temp_display: random and directed stimulus checked every cycle against an arithmetic
// model of the converter and display scan, plus literal display checks for known readings.
module tb_lm75a_temp_display;
    localparam int DIV = 4;
    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] DS = 7'h3F;
    localparam logic [6:0] SEGT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data = 16'h0000;
    logic        busy, done, dp;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;

    lm75a_temp_display #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .data(data), .busy(busy), .done(done),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // {dp_on, d3, d2, d1, d0} from the reading, by plain decimal arithmetic
    function automatic logic [28:0] fmt(input logic [15:0] d);
        logic signed [10:0] ts;
        int tv, m, ip, te;
        ts = d[15:5];
        tv = ts;
        m  = tv < 0 ? -tv : tv;
        ip = m / 8;
        te = (m % 8) * 10 / 8;
        if (tv < 0 && ip >= 100) return {1'b0, DS, DS, DS, DS};
        return {1'b1, tv < 0 ? DS : (ip >= 100 ? SEGT[ip / 100] : BL),
                ip < 10 ? BL : SEGT[(ip / 10) % 10], SEGT[ip % 10], SEGT[te]};
    endfunction

    int          m_k, m_age;
    logic        m_force;
    logic [15:0] m_last;
    logic [28:0] m_disp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            m_k = 0; m_age = 0; m_force = 1'b1; m_last = '0;
            m_disp = {1'b0, BL, BL, BL, BL};
            e_an = 4'hF; e_seg = BL; e_dp = 1'b1;
            chk("rst_an", an, 4'hF);
            chk("rst_seg", seg, BL);
            chk("rst_dp", dp, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
        end else begin
            int idx;
            chk("an", an, e_an);
            chk("seg", seg, e_seg);
            chk("dp", dp, e_dp);
            chk("busy", busy, m_age != 0);
            chk("done", done, m_age == 9);
            if (m_k > 0) chk("an_onehot", $onehot(~an), 1'b1);
            idx   = (m_k / DIV) % 4;
            e_an  = ~(4'b0001 << idx);
            e_seg = m_disp[idx*7 +: 7];
            e_dp  = !(m_disp[28] && idx == 1);
            if (m_age == 9) m_disp = fmt(m_last);
            if (m_age == 0 && (m_force || data != m_last)) begin
                m_last = data; m_force = 1'b0; m_age = 1;
            end else if (m_age != 0) m_age = m_age == 9 ? 0 : m_age + 1;
            m_k++;
        end
    end

    task automatic set_data(input logic [15:0] v);
        @(posedge clk); #2 data = v;
    endtask

    task automatic wait_done(input int maxc, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < maxc);
        chk("done_seen", done, 1'b1);
    endtask

    task automatic wait_busy(input int maxc);
        int n = 0;
        do begin @(negedge clk); n++; end while (!busy && n < maxc);
        chk("busy_seen", busy, 1'b1);
    endtask

    task automatic count_done(input int cyc, input int exp, input string nm);
        int n = 0;
        repeat (cyc) begin @(negedge clk); if (done) n++; end
        chk(nm, n, exp);
    endtask

    task automatic check_disp(input logic [27:0] segs, input logic dp1, input string nm);
        repeat (4 * DIV + 2) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if (an == ~(4'b0001 << i)) begin
                    chk({nm, "_seg"}, seg, segs[i*7 +: 7]);
                    chk({nm, "_dp"}, dp, (i == 1 && dp1) ? 1'b0 : 1'b1);
                end
        end
    endtask

    task automatic conv_check(input logic [15:0] v, input logic [27:0] segs, input logic dp1, input string nm);
        int n;
        set_data(v);
        wait_done(30, n);
        repeat (2) @(negedge clk);
        check_disp(segs, dp1, nm);
    endtask

    initial begin
        int n;
        data = 16'h1900;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        wait_done(30, n);
        chk("first_done_latency", n, 10);
        repeat (2) @(negedge clk);
        check_disp({BL, 7'h24, 7'h12, 7'h40}, 1'b1, "s1_25p0");
        conv_check(16'hE700, {DS, 7'h24, 7'h12, 7'h40}, 1'b1, "s2_m25p0");
        conv_check(16'h7FE0, {7'h79, 7'h24, 7'h78, 7'h00}, 1'b1, "s3_127p8");
        conv_check(16'hFF20, {DS, BL, 7'h40, 7'h00}, 1'b1, "s3_m0p8");
        conv_check(16'h8000, {DS, DS, DS, DS}, 1'b0, "s4_err");
        conv_check(16'h0000, {BL, BL, 7'h40, 7'h40}, 1'b1, "s4_zero");
        set_data(16'hE700);
        wait_busy(10);
        set_data(16'h0C80);
        set_data(16'hE700);
        count_done(30, 1, "s5_one_done");
        check_disp({DS, 7'h24, 7'h12, 7'h40}, 1'b1, "s5_m25p0");
        set_data(16'h1900);
        wait_busy(10);
        set_data(16'h0C80);
        count_done(40, 2, "s5_two_done");
        check_disp({BL, 7'h79, 7'h24, 7'h12}, 1'b1, "s5_12p5");
        set_data(16'h7FE0);
        wait_busy(10);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("s6_an", an, 4'hF);
        chk("s6_seg", seg, BL);
        chk("s6_busy", busy, 1'b0);
        chk("s6_done", done, 1'b0);
        @(posedge clk); #2 rst = 1'b0;
        wait_done(30, n);
        chk("s6_done_latency", n, 10);
        repeat (2) @(negedge clk);
        check_disp({7'h79, 7'h24, 7'h78, 7'h00}, 1'b1, "s6_127p8");
        for (int i = 0; i < 30; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if (i % 7 == 3) v = {v[15:8] | 8'h80, v[7:0]};
            set_data(v);
            repeat ($urandom_range(0, 24)) @(posedge clk);
            if (i == 15) begin
                #2 rst = 1'b1;
                @(posedge clk); #2 rst = 1'b0;
            end
        end
        repeat (40) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
